// File: rtl/bus_fabric.sv
// bus_fabric: memory-bus interconnect between the picorv32 native memory port
// and NUM_SLAVES slave devices.
//   - per-slave base/mask decode (lowest index wins, status window wins over all)
//   - zero-latency ready path gated by the selected slave
//   - watchdog that answers hung or unmapped accesses with an error response
//   - 8-byte status window (error count/flag, error address) with sticky irq
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   mem_valid/addr/wdata/wstrb  core request (wstrb == 0 means read)
//   mem_ready, mem_rdata  core response
//   slv_sel               one-hot slave select
//   slv_ready, slv_rdata  per-slave done and read data (slot i at [32*i+31:32*i])
//   bus_err_irq           sticky bus-error interrupt, cleared via the status window
module bus_fabric #(
    parameter int unsigned                NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0]   SLV_BASE       = {32'h80000010, 32'h80000008,
                                                            32'h80000000, 32'h00000000},
    parameter logic [32*NUM_SLAVES-1:0]   SLV_MASK       = {32'hFFFFFFFC, 32'hFFFFFFF8,
                                                            32'hFFFFFFFC, 32'hFFFFE000},
    parameter int unsigned                TIMEOUT_CYCLES = 255,
    parameter logic [31:0]                ERR_RDATA      = 32'hDEADBEEF,
    parameter logic [31:0]                STAT_BASE      = 32'h800000F0,
    parameter int unsigned                CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      mem_valid,
    input  logic [31:0]               mem_addr,
    input  logic [31:0]               mem_wdata,
    input  logic [3:0]                mem_wstrb,
    output logic                      mem_ready,
    output logic [31:0]               mem_rdata,
    output logic [NUM_SLAVES-1:0]     slv_sel,
    input  logic [NUM_SLAVES-1:0]     slv_ready,
    input  logic [32*NUM_SLAVES-1:0]  slv_rdata,
    output logic                      bus_err_irq
);

    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_ERR,
        S_STAT
    } state_e;

    state_e               state_q, state_d;
    logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [31:0]          err_addr_q, err_addr_d;
    logic                 err_is_wr_q, err_is_wr_d;
    logic                 irq_q, irq_d;
    logic [31:0]          resp_q, resp_d;

    logic [NUM_SLAVES-1:0] hit;
    logic                  any_hit;
    logic [IDX_W-1:0]      sidx;
    logic                  stat_hit;
    logic                  wd_expired;
    logic                  sel_ok;
    logic                  sel_ready;
    logic [31:0]           stat_word;
    logic                  stat_clr;
    logic                  unused_wdata;

    // Write data goes straight from the core to the slaves; the fabric never stores it.
    assign unused_wdata = ^mem_wdata;

    always_comb begin
        hit     = '0;
        any_hit = 1'b0;
        sidx    = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            hit[i] = ((mem_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]);
            if (hit[i] && !any_hit) begin
                sidx    = IDX_W'(i);
                any_hit = 1'b1;
            end
        end
    end

    assign stat_hit   = ((mem_addr & 32'hFFFFFFF8) == STAT_BASE);
    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES));

    // The select drops in the timeout cycle unless the slave answers in that very
    // cycle, so a ready coinciding with the timeout still completes normally.
    // reset_n gates the select so it falls asynchronously while reset is held.
    assign sel_ok = reset_n && mem_valid && !stat_hit && any_hit &&
                    ((state_q == S_IDLE) ||
                     ((state_q == S_ACTIVE) && !(wd_expired && !slv_ready[sidx])));
    assign sel_ready = sel_ok && slv_ready[sidx];

    assign slv_sel     = sel_ok ? (NUM_SLAVES'(1) << sidx) : '0;
    assign mem_ready   = sel_ready || (state_q == S_ERR) || (state_q == S_STAT);
    assign mem_rdata   = sel_ok ? slv_rdata[32*sidx +: 32] : resp_q;
    assign bus_err_irq = irq_q;

    always_comb begin
        stat_word                = '0;
        stat_word[CNT_WIDTH-1:0] = err_cnt_q;
        stat_word[31]            = err_is_wr_q;
    end

    assign stat_clr = (state_q == S_STAT) && (mem_wstrb != 4'b0) && !mem_addr[2];

    always_comb begin
        state_d     = state_q;
        wd_cnt_d    = wd_cnt_q;
        resp_d      = resp_q;
        err_cnt_d   = err_cnt_q;
        err_addr_d  = err_addr_q;
        err_is_wr_d = err_is_wr_q;
        irq_d       = irq_q;

        if (stat_clr) begin
            err_cnt_d   = '0;
            err_is_wr_d = 1'b0;
            irq_d       = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    if (stat_hit) begin
                        state_d = S_STAT;
                        resp_d  = mem_addr[2] ? err_addr_q : stat_word;
                    end else if (!any_hit) begin
                        state_d = S_ERR;
                        resp_d  = ERR_RDATA;
                    end else if (!sel_ready) begin
                        state_d  = S_ACTIVE;
                        wd_cnt_d = WD_W'(1);
                    end
                end
            end
            S_ACTIVE: begin
                if (sel_ready || !mem_valid) begin
                    state_d = S_IDLE;
                end else if (wd_expired) begin
                    state_d = S_ERR;
                    resp_d  = ERR_RDATA;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end
            S_ERR: begin
                state_d     = S_IDLE;
                err_addr_d  = mem_addr;
                err_is_wr_d = |mem_wstrb;
                irq_d       = 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
                end
            end
            S_STAT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wd_cnt_q    <= '0;
            resp_q      <= '0;
            err_cnt_q   <= '0;
            err_addr_q  <= '0;
            err_is_wr_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wd_cnt_q    <= wd_cnt_d;
            resp_q      <= resp_d;
            err_cnt_q   <= err_cnt_d;
            err_addr_q  <= err_addr_d;
            err_is_wr_q <= err_is_wr_d;
            irq_q       <= irq_d;
        end
    end

endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: randomized self-checking bench for bus_fabric.
// The reference model decodes addresses from an explicit range table and
// predicts each transaction's completion cycle, select pattern, response data
// and the status-window contents.
module tb_bus_fabric;

    localparam int unsigned NS = 4;
    localparam int unsigned TO = 8;
    localparam logic [32*NS-1:0] BASE = {32'h80000000, 32'h80000000, 32'h80000000, 32'h00000000};
    localparam logic [32*NS-1:0] MASK = {32'hFFFFFF00, 32'hFFFFFFF0, 32'hFFFFFFFC, 32'hFFFFE000};
    localparam logic [31:0] STAT = 32'h800000F0;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic            clk;
    logic            reset_n;
    logic            mem_valid;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ready;
    logic [31:0]     mem_rdata;
    logic [NS-1:0]   slv_sel;
    logic [NS-1:0]   slv_ready;
    logic [32*NS-1:0] slv_rdata;
    logic            bus_err_irq;

    bus_fabric #(
        .NUM_SLAVES    (NS),
        .SLV_BASE      (BASE),
        .SLV_MASK      (MASK),
        .TIMEOUT_CYCLES(TO),
        .ERR_RDATA     (ERRD),
        .STAT_BASE     (STAT),
        .CNT_WIDTH     (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .slv_sel    (slv_sel),
        .slv_ready  (slv_ready),
        .slv_rdata  (slv_rdata),
        .bus_err_irq(bus_err_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Reference model state
    logic [15:0] m_cnt;
    logic [31:0] m_addr;
    logic        m_iswr;
    logic        m_irq;
    logic [31:0] rdv [NS];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Address map as ranges, first match wins: 4 = status window, -1 = unmapped.
    function automatic int target(input logic [31:0] a);
        if (a >= 32'h800000F0 && a <= 32'h800000F7) return 4;
        if (a <= 32'h00001FFF) return 0;
        if (a >= 32'h80000000 && a <= 32'h80000003) return 1;
        if (a >= 32'h80000000 && a <= 32'h8000000F) return 2;
        if (a >= 32'h80000000 && a <= 32'h800000FF) return 3;
        return -1;
    endfunction

    function automatic logic [31:0] stat_value(input logic [31:0] a);
        if ((a - STAT) >= 32'd4) return m_addr;
        return {m_iswr, 15'd0, m_cnt};
    endfunction

    task automatic model_reset();
        m_cnt  = '0;
        m_addr = '0;
        m_iswr = 1'b0;
        m_irq  = 1'b0;
    endtask

    task automatic drive_noise(input int tgt, input bit tgt_rdy);
        logic [31:0]   r;
        logic [NS-1:0] rdy;
        for (int i = 0; i < NS; i++) rdv[i] = $urandom;
        slv_rdata = {rdv[3], rdv[2], rdv[1], rdv[0]};
        r   = $urandom;
        rdy = r[NS-1:0];
        if (tgt >= 0 && tgt < NS) rdy[tgt] = tgt_rdy;
        slv_ready = rdy;
    endtask

    // One cycle with no request; unselected ready noise must never reach the core.
    task automatic idle_cycle();
        mem_valid = 1'b0;
        mem_addr  = $urandom;
        mem_wstrb = 4'b0;
        drive_noise(-1, 1'b0);
        #4;
        check_eq("idle_ready", 32'(mem_ready), 32'd0);
        check_eq("idle_sel", 32'(slv_sel), 32'd0);
        check_eq("irq", 32'(bus_err_irq), 32'(m_irq));
        @(posedge clk);
        #1;
    endtask

    // Full transaction; the target slave raises ready from cycle 'lat' onwards
    // (cycle 0 is the first cycle mem_valid is high).
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb, input int lat);
        int          tgt;
        int          done;
        bit          err;
        bit          sel_on;
        logic [31:0] exp_sel;
        tgt = target(addr);
        if (tgt < 0) begin
            done = 1; err = 1'b1;
        end else if (tgt == 4) begin
            done = 1; err = 1'b0;
        end else if (lat <= int'(TO)) begin
            done = lat; err = 1'b0;
        end else begin
            done = int'(TO) + 1; err = 1'b1;
        end
        for (int c = 0; c <= done; c++) begin
            mem_valid = 1'b1;
            mem_addr  = addr;
            mem_wstrb = wstrb;
            mem_wdata = $urandom;
            drive_noise(tgt, c >= lat);
            #4;
            sel_on  = (tgt >= 0 && tgt < 4) && ((lat <= int'(TO)) || (c < int'(TO)));
            exp_sel = sel_on ? (32'd1 << tgt) : 32'd0;
            check_eq("sel", 32'(slv_sel), exp_sel);
            check_eq("ready", 32'(mem_ready), 32'(c == done));
            check_eq("irq", 32'(bus_err_irq), 32'(m_irq));
            if (c == done) begin
                if (err) check_eq("err_rdata", mem_rdata, ERRD);
                else if (wstrb == 4'b0) begin
                    if (tgt == 4) check_eq("stat_rdata", mem_rdata, stat_value(addr));
                    else          check_eq("slv_rdata", mem_rdata, rdv[tgt]);
                end
            end
            @(posedge clk);
            #1;
        end
        if (err) begin
            m_addr = addr;
            m_iswr = |wstrb;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_irq  = 1'b1;
        end else if (tgt == 4 && wstrb != 4'b0 && (addr - STAT) < 32'd4) begin
            m_cnt  = '0;
            m_iswr = 1'b0;
            m_irq  = 1'b0;
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by 2ms");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] r;
        logic [3:0]  ws;
        int          k;

        reset_n   = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        slv_ready = '0;
        slv_rdata = '0;
        model_reset();
        #22;
        check_eq("rst_ready", 32'(mem_ready), 32'd0);
        check_eq("rst_sel", 32'(slv_sel), 32'd0);
        check_eq("rst_irq", 32'(bus_err_irq), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle_cycle();

        // SRAM read with one wait cycle, then unmapped read and status readback
        run_txn(32'h00000100, 4'b0, 1);
        run_txn(STAT, 4'b0, 0);
        run_txn(32'h40000000, 4'b0, 0);
        run_txn(STAT, 4'b0, 0);
        run_txn(STAT + 32'd4, 4'b0, 0);
        run_txn(STAT, 4'hF, 0);
        idle_cycle();

        // Hung write to slot 3 times out; status shows write flag and count 1
        run_txn(32'h80000010, 4'hF, 1000);
        run_txn(STAT, 4'b0, 0);
        check_eq("stat_after_hang", {m_iswr, 15'd0, m_cnt}, 32'h80000001);

        // Overlapping windows, and slot 3 just above the status window
        run_txn(32'h80000002, 4'b0, 2);
        run_txn(32'h8000000C, 4'b0, 0);
        run_txn(32'h80000020, 4'b0, 3);
        run_txn(32'h800000F8, 4'b0, 1);
        run_txn(32'h800000EF, 4'b0, 0);

        // Ready exactly at the timeout wins; one cycle later is an error
        run_txn(32'h80000010, 4'b0, TO);
        run_txn(32'h80000010, 4'b0, TO + 1);
        run_txn(STAT, 4'h1, 0);
        idle_cycle();
        run_txn(STAT, 4'b0, 0);

        // Abort: core drops mem_valid while ACTIVE, no error recorded
        run_txn(32'h40001234, 4'h3, 0);
        for (int c = 0; c < 4; c++) begin
            mem_valid = 1'b1;
            mem_addr  = 32'h80000030;
            mem_wstrb = 4'b0;
            drive_noise(3, 1'b0);
            #4;
            check_eq("abort_sel", 32'(slv_sel), 32'h8);
            check_eq("abort_ready", 32'(mem_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        idle_cycle();
        idle_cycle();
        run_txn(STAT, 4'b0, 0);
        run_txn(STAT + 32'd4, 4'b0, 0);

        // Reset during ACTIVE at watchdog count 5
        for (int c = 0; c <= 5; c++) begin
            mem_valid = 1'b1;
            mem_addr  = 32'h80000040;
            mem_wstrb = 4'b0;
            drive_noise(3, 1'b0);
            #4;
            check_eq("pre_rst_sel", 32'(slv_sel), 32'h8);
            if (c < 5) begin
                @(posedge clk);
                #1;
            end
        end
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_ready", 32'(mem_ready), 32'd0);
        check_eq("async_rst_sel", 32'(slv_sel), 32'd0);
        check_eq("async_rst_irq", 32'(bus_err_irq), 32'd0);
        mem_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle_cycle();
        run_txn(STAT, 4'b0, 0);
        run_txn(STAT + 32'd4, 4'b0, 0);

        // Randomized traffic
        repeat (200) begin
            k = $urandom_range(0, 5);
            r = $urandom;
            case (k)
                0:       a = r & 32'h00001FFF;
                1, 2:    a = 32'h80000000 | (r & 32'h000000FF);
                3:       a = STAT | 32'($urandom_range(0, 7));
                4:       a = 32'h40000000 | (r & 32'h3FFFFFFF);
                default: a = 32'h80000000 | (r & 32'h0000001F);
            endcase
            r  = $urandom;
            ws = ($urandom_range(0, 1) == 0) ? 4'b0 : r[3:0];
            run_txn(a, ws, $urandom_range(0, TO + 2));
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        run_txn(STAT, 4'b0, 0);
        run_txn(STAT + 32'd4, 4'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
